// File: rtl/core_seq_if.sv
// Handshake and control bundle between the core sequencer and the fetch/decode/memory side.
// The master modport is the sequencer's view; slave is the datapath/memory view.
interface core_seq_if #(
   parameter int CNT_WIDTH = 64
);
   logic                 imem_req;
   logic                 imem_ack;
   logic                 ir_we;
   logic [6:0]           ir_opcode;
   logic                 wb_reg_i;
   logic                 csr_wb_i;
   logic                 dmem_req;
   logic                 dmem_we;
   logic                 dmem_ack;
   logic                 pc_we;
   logic                 reg_we;
   logic                 csr_we;
   logic                 halt_req;
   logic                 halted;
   logic [1:0]           err;
   logic [CNT_WIDTH-1:0] retire_cnt;

   modport master (
      output imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, csr_we,
             halted, err, retire_cnt,
      input  imem_ack, ir_opcode, wb_reg_i, csr_wb_i, dmem_ack, halt_req
   );

   modport slave (
      input  imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, csr_we,
             halted, err, retire_cnt,
      output imem_ack, ir_opcode, wb_reg_i, csr_wb_i, dmem_ack, halt_req
   );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle core sequencer: fetch -> exec -> (mem) -> write back, with retire
// counting, halt parking, and sticky errors for illegal opcodes and bus timeouts.
module core_seq #(
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_WIDTH   = 64
) (
   input  logic       clk,
   input  logic       rst,
   core_seq_if.master bus
);
   localparam int                WAIT_W     = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT);
   localparam bit                TIMEOUT_EN = (ACK_TIMEOUT != 0);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] LEGAL_OPS [8] = '{
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011
   };

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_ILL  = 2'b01;
   localparam logic [1:0] ERR_IMEM = 2'b10;
   localparam logic [1:0] ERR_DMEM = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_MEM   = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t               state_reg,  state_next;
   logic [WAIT_W-1:0]    wait_reg,   wait_next;
   logic [1:0]           err_reg,    err_next;
   logic [CNT_WIDTH-1:0] cnt_reg,    cnt_next;
   logic                 store_reg,  store_next;

   logic [7:0]           legal_hit;
   logic                 op_mem;
   logic                 op_legal;
   logic [WAIT_W-1:0]    wait_inc;
   logic                 timeout_hit;

   // Opcode classification against the table of register/branch/jump/system ops.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_legal
         assign legal_hit[gi] = (bus.ir_opcode == LEGAL_OPS[gi]);
      end
   endgenerate

   assign op_legal    = |legal_hit;
   assign op_mem      = (bus.ir_opcode == OP_LOAD) || (bus.ir_opcode == OP_STORE);
   assign wait_inc    = wait_reg + WAIT_W'(1);
   // The count that would be reached this cycle; an ack in the same cycle takes priority.
   assign timeout_hit = TIMEOUT_EN && (wait_inc == WAIT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH: begin
            if (bus.imem_ack) begin
               state_next = S_EXEC;
            end else if (timeout_hit) begin
               state_next = S_HALT;
            end
         end
         S_EXEC: begin
            if (op_mem) begin
               state_next = S_MEM;
            end else if (op_legal) begin
               state_next = S_WB;
            end else begin
               state_next = S_HALT;
            end
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               state_next = S_WB;
            end else if (timeout_hit) begin
               state_next = S_HALT;
            end
         end
         S_WB: begin
            state_next = bus.halt_req ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if ((err_reg == ERR_NONE) && !bus.halt_req) begin
               state_next = S_FETCH;
            end
         end
         default: state_next = S_FETCH;
      endcase
   end

   always_comb begin
      bus.imem_req = 1'b0;
      bus.ir_we    = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      bus.pc_we    = 1'b0;
      bus.reg_we   = 1'b0;
      bus.csr_we   = 1'b0;
      bus.halted   = 1'b0;
      if (!rst) begin
         case (state_reg)
            S_FETCH: begin
               bus.imem_req = 1'b1;
               bus.ir_we    = bus.imem_ack;
            end
            S_MEM: begin
               bus.dmem_req = 1'b1;
               bus.dmem_we  = store_reg;
            end
            S_WB: begin
               bus.pc_we  = 1'b1;
               bus.reg_we = bus.wb_reg_i;
               bus.csr_we = bus.csr_wb_i;
            end
            S_HALT: begin
               bus.halted = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.err        = rst ? ERR_NONE : err_reg;
   assign bus.retire_cnt = rst ? '0 : cnt_reg;

   // Wait counter, sticky error, retire counter and the latched store flag.
   always_comb begin
      wait_next  = wait_reg;
      err_next   = err_reg;
      cnt_next   = cnt_reg;
      store_next = store_reg;
      case (state_reg)
         S_FETCH: begin
            if (!bus.imem_ack) begin
               if (timeout_hit) begin
                  err_next = ERR_IMEM;
               end else if (TIMEOUT_EN) begin
                  wait_next = wait_inc;
               end
            end
         end
         S_EXEC: begin
            wait_next  = '0;
            store_next = (bus.ir_opcode == OP_STORE);
            if (!op_mem && !op_legal) begin
               err_next = ERR_ILL;
            end
         end
         S_MEM: begin
            if (!bus.dmem_ack) begin
               if (timeout_hit) begin
                  err_next = ERR_DMEM;
               end else if (TIMEOUT_EN) begin
                  wait_next = wait_inc;
               end
            end
         end
         S_WB: begin
            wait_next = '0;
            cnt_next  = cnt_reg + CNT_WIDTH'(1);
         end
         S_HALT: begin
            wait_next = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_reg  <= '0;
         err_reg   <= ERR_NONE;
         cnt_reg   <= '0;
         store_reg <= 1'b0;
      end else begin
         wait_reg  <= wait_next;
         err_reg   <= err_next;
         cnt_reg   <= cnt_next;
         store_reg <= store_next;
      end
   end
endmodule
